// File: rtl/div_request_sequencer.sv
// div_request_sequencer: front end for the 8-bit non-restoring divider.
// Operand pairs are buffered, and divisors the divider cannot handle
// (zero, or bit 7 set) are answered directly. Every accepted operation
// re-arms the divider with a one-cycle div_rst_n pulse, then drives
// div_req under a watchdog. Results leave on a valid/ready stream.
//
// Handshakes: a transfer happens on a clk edge where valid and ready are
// both high. Once out_valid is high, it stays high with stable data until
// out_ready is seen. in_ready does not depend on in_valid.
//
// Build option: define DIV_SEQ_FIFO_EN for a FIFO_DEPTH-entry circular
// input FIFO. Otherwise, a single holding register is used.
module div_request_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_dividend,
  input  logic [7:0]  in_divisor,
  output logic        div_rst_n,
  output logic        div_req,
  output logic [15:0] div_values,
  input  logic        div_ack,
  input  logic [15:0] div_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_quotient,
  output logic [7:0]  out_remainder,
  output logic [1:0]  out_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_REQ  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           started_q;
  logic [15:0]    values_q, values_d;
  logic [7:0]     quo_q, quo_d;
  logic [7:0]     rem_q, rem_d;
  logic [1:0]     err_q, err_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic           push, pop;
  logic           buf_empty, buf_can_push;
  logic [15:0]    head;

  assign in_ready = started_q & buf_can_push;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == S_IDLE) & ~buf_empty;

  // Holds in_ready and div_rst_n inactive until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) started_q <= 1'b0;
    else          started_q <= 1'b1;
  end

`ifdef DIV_SEQ_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  // The extra pointer MSB separates full from empty after wrap.
  assign buf_empty    = (wr_ptr_q == rd_ptr_q);
  assign buf_can_push = ~((wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]));
  assign head         = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO pointers; push and pop may happen on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; the contents are meaningful only between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_dividend, in_divisor};
  end
`else
  logic        hold_valid_q;
  logic [15:0] hold_data_q;

  // A full holding register blocks pushes, so a push never coincides with a pop.
  assign buf_empty    = ~hold_valid_q;
  assign buf_can_push = ~hold_valid_q;
  assign head         = hold_data_q;

  // Single-entry holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= {in_dividend, in_divisor};
    end
  end
`endif

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      values_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      err_q    <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      values_q <= values_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  // Next-state logic: screen divisors, re-arm, request with watchdog, then present the result.
  always_comb begin
    state_d  = state_q;
    values_d = values_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    err_d    = err_q;
    wdog_d   = wdog_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head[7:0] == 8'd0) begin
            quo_d   = 8'hFF;
            rem_d   = head[15:8];
            err_d   = 2'b01;
            state_d = S_OUT;
          end else if (head[7]) begin
            quo_d   = 8'h00;
            rem_d   = head[15:8];
            err_d   = 2'b10;
            state_d = S_OUT;
          end else begin
            values_d = head;
            state_d  = S_ARM;
          end
        end
      end
      S_ARM: begin
        wdog_d  = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (div_ack) begin
          quo_d   = div_result[7:0];
          rem_d   = div_result[15:8];
          err_d   = 2'b00;
          state_d = S_OUT;
        end else if (wdog_q == WD_LAST) begin
          quo_d   = 8'h00;
          rem_d   = 8'h00;
          err_d   = 2'b11;
          state_d = S_OUT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign div_rst_n     = started_q & (state_q != S_ARM);
  assign div_req       = (state_q == S_REQ);
  assign div_values    = values_q;
  assign out_valid     = (state_q == S_OUT);
  assign out_quotient  = quo_q;
  assign out_remainder = rem_q;
  assign out_err       = err_q;
  assign busy          = (state_q != S_IDLE) | ~buf_empty;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Bench for div_request_sequencer: directed operand pairs, a behavioural
// divider, and a scoreboard queue drained by an output monitor.
module tb_div_request_sequencer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_dividend;
  logic [7:0]  in_divisor;
  logic        div_rst_n;
  logic        div_req;
  logic [15:0] div_values;
  logic        div_ack;
  logic [15:0] div_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_quotient;
  logic [7:0]  out_remainder;
  logic [1:0]  out_err;
  logic        busy;
  logic [1:0]  dbg_state;

  div_request_sequencer #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .div_rst_n(div_rst_n),
    .div_req(div_req), .div_values(div_values), .div_ack(div_ack),
    .div_result(div_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_err(out_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and queues ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];   // {err, remainder, quotient}
  logic [15:0] val_q[$];   // expected div_values per divider operation

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- divider model ----------------
  logic        model_ack;
  logic [15:0] model_res;
  logic        stray_ack;
  bit          ack_en;
  int          ack_delay;
  int          model_cnt;

  assign div_ack    = model_ack | stray_ack;
  assign div_result = stray_ack ? 16'hA5A5 : model_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_ack <= 1'b0;
      model_res <= '0;
      model_cnt <= 0;
    end else begin
      model_ack <= 1'b0;
      if (div_req && !model_ack && ack_en) begin
        if (model_cnt >= ack_delay - 1) begin
          model_ack <= 1'b1;
          model_res <= {div_values[15:8] % div_values[7:0], div_values[15:8] / div_values[7:0]};
          model_cnt <= 0;
        end else begin
          model_cnt <= model_cnt + 1;
        end
      end else begin
        model_cnt <= 0;
      end
    end
  end

  // ---------------- divider-side checker ----------------
  int   low_cnt = 0;
  int   req_rises = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      low_cnt  = 0;
      req_prev = 1'b0;
    end else begin
      if (!div_rst_n) low_cnt++;
      if (div_req && !req_prev) begin
        check("rst_pulse_before_req", low_cnt, 1);
        low_cnt = 0;
        req_rises++;
      end
      if (div_req || !div_rst_n) begin
        if (val_q.size() == 0) check("div_values_unexpected_op", 1, 0);
        else check("div_values_hold", div_values, val_q[0]);
      end
      if (!div_req && req_prev && val_q.size() != 0) void'(val_q.pop_front());
      req_prev = div_req;
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  logic        held_v = 1'b0;
  logic [17:0] held;

  always @(negedge clk) begin
    logic [17:0] cur;
    if (!reset_n) begin
      held_v = 1'b0;
    end else if (out_valid) begin
      cur = {out_err, out_remainder, out_quotient};
      if (held_v) check("out_stable", cur, held);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got %0h expected no output at %0t", cur, $time);
        end else begin
          check("out_result", cur, exp_q.pop_front());
        end
        held_v = 1'b0;
      end else begin
        held   = cur;
        held_v = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers are called at posedge + 1.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [17:0] exp,
                      input bit to_div, output int waited);
    waited = 0;
    while (!in_ready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("push_in_ready_timeout", 0, 1);
      return;
    end
    exp_q.push_back(exp);
    if (to_div) val_q.push_back({a, b});
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    @(posedge clk); #1;
    in_valid    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy && !out_valid && in_ready && exp_q.size() == 0) return;
    end
    check("wait_idle_timeout", 0, 1);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 0);
    check("rst_div_rst_n", div_rst_n, 0);
    check("rst_div_req", div_req, 0);
    check("rst_div_values", div_values, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_quotient", out_quotient, 0);
    check("rst_out_remainder", out_remainder, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    reset_n = 1'b1;
    check("release_in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1);
    check("release_div_rst_n", div_rst_n, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int r0;
    int n;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;
    stray_ack   = 1'b0;
    ack_en      = 1'b1;
    ack_delay   = 43;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    release_reset();

    // 100 / 7 through the divider
    push(8'd100, 8'd7, {2'b00, 8'd2, 8'd14}, 1'b1, w);
    wait_idle();

    // 55 / 0 bypass: no divider traffic; result one cycle after the pop
    r0 = req_rises;
    push(8'd55, 8'd0, {2'b01, 8'd55, 8'hFF}, 1'b0, w);
    @(negedge clk);
    check("bypass0_not_yet", out_valid, 0);
    @(negedge clk);
    check("bypass0_valid", out_valid, 1);
    wait_idle();
    check("bypass0_no_req", req_rises, r0);
    check("bypass0_no_rst_pulse", low_cnt, 0);

    // 200 / 130 bypass
    push(8'd200, 8'd130, {2'b10, 8'd200, 8'h00}, 1'b0, w);
    @(negedge clk);
    check("bypass130_not_yet", out_valid, 0);
    @(negedge clk);
    check("bypass130_valid", out_valid, 1);
    wait_idle();

    // divisor boundaries: 128 rejected, 127 accepted; zero dividend
    ack_delay = 3;
    push(8'd77, 8'd128, {2'b10, 8'd77, 8'h00}, 1'b0, w);
    push(8'd254, 8'd127, {2'b00, 8'd0, 8'd2}, 1'b1, w);
    push(8'd0, 8'd1, {2'b00, 8'd0, 8'd0}, 1'b1, w);
    push(8'd255, 8'd1, {2'b00, 8'd0, 8'd255}, 1'b1, w);
    wait_idle();
    check("bypass_no_rst_pulse_after", low_cnt, 0);

    // stray ack while idle must be ignored
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stray_ack_no_output", out_valid, 0);
    check("stray_ack_idle", busy, 0);

    // watchdog timeout: divider never acks
    ack_en = 1'b0;
    push(8'd90, 8'd9, {2'b11, 8'd0, 8'd0}, 1'b1, w);
    n = 0;
    while (!div_req && n < 20) begin @(negedge clk); n++; end
    check("timeout_req_seen", div_req, 1);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check("timeout_latency", n, TO);
    check("timeout_req_dropped", div_req, 0);
    wait_idle();
    ack_en = 1'b1;

    // next operation after a timeout proceeds normally
    push(8'd100, 8'd7, {2'b00, 8'd2, 8'd14}, 1'b1, w);
    wait_idle();

`ifdef DIV_SEQ_FIFO_EN
    // FIFO build: five back-to-back pushes while results are held
    ack_delay = 5;
    out_ready = 1'b0;
    r0 = 0;
    push(8'd10, 8'd3, {2'b00, 8'd1, 8'd3}, 1'b1, w); r0 += w;
    push(8'd20, 8'd3, {2'b00, 8'd2, 8'd6}, 1'b1, w); r0 += w;
    push(8'd30, 8'd4, {2'b00, 8'd2, 8'd7}, 1'b1, w); r0 += w;
    push(8'd40, 8'd6, {2'b00, 8'd4, 8'd6}, 1'b1, w); r0 += w;
    push(8'd50, 8'd7, {2'b00, 8'd1, 8'd7}, 1'b1, w); r0 += w;
    check("fifo_no_stall", r0, 0);
    check("fifo_full_in_ready", in_ready, 0);
    repeat (20) @(posedge clk);
    #1;
    check("fifo_still_full", in_ready, 0);
    out_ready = 1'b1;
    wait_idle();
`else
    // holding register: second pair waits, third stalls while the result is held
    ack_delay = 3;
    out_ready = 1'b0;
    fork
      begin
        push(8'd55, 8'd0, {2'b01, 8'd55, 8'hFF}, 1'b0, w);
        push(8'd200, 8'd200, {2'b10, 8'd200, 8'h00}, 1'b0, w);
        push(8'd9, 8'd3, {2'b00, 8'd0, 8'd3}, 1'b1, w);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        check("hold_full_in_ready", in_ready, 0);
        check("hold_busy", busy, 1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
`endif

    // reset asserted during REQ with a second pair buffered
    ack_delay = 43;
    push(8'd100, 8'd7, {2'b00, 8'd2, 8'd14}, 1'b1, w);
    push(8'd9, 8'd3, {2'b00, 8'd0, 8'd3}, 1'b1, w);
    n = 0;
    while (!div_req && n < 20) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk);
    #3;
    check("pre_reset_in_req", div_req, 1);
    reset_n = 1'b0;
    exp_q.delete();
    val_q.delete();
    #1;
    check_reset_values();
    release_reset();
    check("post_reset_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_no_output", out_valid, 0);
    check("post_reset_still_idle", busy, 0);

    // normal operation after reset
    ack_delay = 7;
    push(8'd63, 8'd8, {2'b00, 8'd7, 8'd7}, 1'b1, w);
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "time limit");
  end

endmodule
